// File: rtl/id_stage.sv
// RV32I decode stage (OP-IMM, OP, LUI, AUIPC) with operand forwarding, load-use stall,
// valid/ready handshake and flush; results held in an ID/EX output register.
module id_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         pc,
  input  logic [31:0]             inst,
  output logic [4:0]              reg1_addr_o,
  output logic [4:0]              reg2_addr_o,
  output logic                    reg1_read_enable,
  output logic                    reg2_read_enable,
  input  logic [XLEN-1:0]         reg1_data_i,
  input  logic [XLEN-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [5*NUM_FWD-1:0]    fwd_addr,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         reg1,
  output logic [XLEN-1:0]         reg2,
  output logic [XLEN-1:0]         Imm,
  output logic [XLEN-1:0]         out_pc,
  output logic [4:0]              rd,
  output logic                    rd_enable,
  output logic [3:0]              aluop,
  output logic [2:0]              alusel,
  output logic                    illegal
);

  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluSll = 4'd2, AluSlt = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4, AluXor = 4'd5, AluSrl = 4'd6, AluSra = 4'd7;
  localparam logic [3:0] AluOr = 4'd8, AluAnd = 4'd9, AluNop = 4'd15;
  localparam logic [2:0] SelNop = 3'd0, SelLogic = 3'd1, SelArith = 3'd2;
  localparam logic [2:0] SelShift = 3'd3, SelCompare = 3'd4;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd_field;
  logic [31:0]     imm_u;
  logic            rs1_en, rs2_en, use_imm, sel_pc, rd_wr, illegal_n;
  logic [XLEN-1:0] imm_n;
  logic [3:0]      aluop_n;
  logic [2:0]      alusel_n;

  assign opcode   = inst[6:0];
  assign rd_field = inst[11:7];
  assign funct3   = inst[14:12];
  assign rs1      = inst[19:15];
  assign rs2      = inst[24:20];
  assign funct7   = inst[31:25];
  assign imm_u    = {inst[31:12], 12'b0};

  always_comb begin
    rs1_en    = 1'b0;
    rs2_en    = 1'b0;
    use_imm   = 1'b0;
    sel_pc    = 1'b0;
    rd_wr     = 1'b0;
    illegal_n = 1'b0;
    imm_n     = '0;
    aluop_n   = AluNop;
    alusel_n  = SelNop;
    case (opcode)
      OpcOpImm: begin
        rs1_en  = 1'b1;
        use_imm = 1'b1;
        rd_wr   = 1'b1;
        imm_n   = {{(XLEN-12){inst[31]}}, inst[31:20]};
        case (funct3)
          3'b000: begin aluop_n = AluAdd;  alusel_n = SelArith;   end
          3'b010: begin aluop_n = AluSlt;  alusel_n = SelCompare; end
          3'b011: begin aluop_n = AluSltu; alusel_n = SelCompare; end
          3'b100: begin aluop_n = AluXor;  alusel_n = SelLogic;   end
          3'b110: begin aluop_n = AluOr;   alusel_n = SelLogic;   end
          3'b111: begin aluop_n = AluAnd;  alusel_n = SelLogic;   end
          3'b001: begin
            imm_n     = XLEN'(rs2);
            aluop_n   = AluSll;
            alusel_n  = SelShift;
            illegal_n = (funct7 != 7'b0000000);
          end
          default: begin
            imm_n     = XLEN'(rs2);
            aluop_n   = inst[30] ? AluSra : AluSrl;
            alusel_n  = SelShift;
            illegal_n = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
        endcase
      end
      OpcOp: begin
        rs1_en = 1'b1;
        rs2_en = 1'b1;
        rd_wr  = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  begin aluop_n = AluAdd;  alusel_n = SelArith;   end
            3'b001:  begin aluop_n = AluSll;  alusel_n = SelShift;   end
            3'b010:  begin aluop_n = AluSlt;  alusel_n = SelCompare; end
            3'b011:  begin aluop_n = AluSltu; alusel_n = SelCompare; end
            3'b100:  begin aluop_n = AluXor;  alusel_n = SelLogic;   end
            3'b101:  begin aluop_n = AluSrl;  alusel_n = SelShift;   end
            3'b110:  begin aluop_n = AluOr;   alusel_n = SelLogic;   end
            default: begin aluop_n = AluAnd;  alusel_n = SelLogic;   end
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          aluop_n  = AluSub;
          alusel_n = SelArith;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          aluop_n  = AluSra;
          alusel_n = SelShift;
        end else begin
          illegal_n = 1'b1;
        end
      end
      OpcLui, OpcAuipc: begin
        use_imm  = 1'b1;
        sel_pc   = (opcode == OpcAuipc);
        rd_wr    = 1'b1;
        imm_n    = XLEN'($signed(imm_u));
        aluop_n  = AluAdd;
        alusel_n = SelArith;
      end
      default: illegal_n = 1'b1;
    endcase
    // Illegal encodings still flow through, but as a harmless no-op payload.
    if (illegal_n) begin
      aluop_n  = AluNop;
      alusel_n = SelNop;
      rd_wr    = 1'b0;
    end
  end

  assign reg1_addr_o      = rst ? 5'd0 : rs1;
  assign reg2_addr_o      = rst ? 5'd0 : rs2;
  assign reg1_read_enable = !rst && rs1_en;
  assign reg2_read_enable = !rst && rs2_en;

  logic [XLEN-1:0] fwd1, fwd2, op1, op2;
  logic            hit1, hit2, pend1, pend2, stall;

  // Scan oldest to youngest so the lowest-index match overrides.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    pend1 = 1'b0;
    pend2 = 1'b0;
    fwd1  = '0;
    fwd2  = '0;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_addr[5*i +: 5] == rs1) begin
        hit1  = 1'b1;
        pend1 = fwd_pending[i];
        fwd1  = fwd_data[XLEN*i +: XLEN];
      end
      if (fwd_valid[i] && fwd_addr[5*i +: 5] == rs2) begin
        hit2  = 1'b1;
        pend2 = fwd_pending[i];
        fwd2  = fwd_data[XLEN*i +: XLEN];
      end
    end
    if (!rs1_en)          op1 = sel_pc ? pc : '0;
    else if (rs1 == 5'd0) op1 = '0;
    else if (hit1)        op1 = fwd1;
    else                  op1 = reg1_data_i;
    if (!rs2_en)          op2 = use_imm ? imm_n : '0;
    else if (rs2 == 5'd0) op2 = '0;
    else if (hit2)        op2 = fwd2;
    else                  op2 = reg2_data_i;
    stall = (rs1_en && rs1 != 5'd0 && hit1 && pend1) ||
            (rs2_en && rs2 != 5'd0 && hit2 && pend2);
  end

  logic            out_valid_q, out_valid_d, rd_enable_q, rd_enable_d, illegal_q, illegal_d;
  logic [XLEN-1:0] reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d, pc_q, pc_d;
  logic [4:0]      rd_q, rd_d;
  logic [3:0]      aluop_q, aluop_d;
  logic [2:0]      alusel_q, alusel_d;
  logic            accept;

  assign in_ready = !rst && !flush && !stall && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    rd_enable_d = rd_enable_q;
    aluop_d     = aluop_q;
    alusel_d    = alusel_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      reg1_d      = op1;
      reg2_d      = op2;
      imm_d       = imm_n;
      pc_d        = pc;
      rd_d        = rd_field;
      rd_enable_d = rd_wr && (rd_field != 5'd0);
      aluop_d     = aluop_n;
      alusel_d    = alusel_n;
      illegal_d   = illegal_n;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      rd_enable_q <= 1'b0;
      aluop_q     <= AluNop;
      alusel_q    <= SelNop;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      rd_enable_q <= rd_enable_d;
      aluop_q     <= aluop_d;
      alusel_q    <= alusel_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign reg1      = reg1_q;
  assign reg2      = reg2_q;
  assign Imm       = imm_q;
  assign out_pc    = pc_q;
  assign rd        = rd_q;
  assign rd_enable = rd_enable_q;
  assign aluop     = aluop_q;
  assign alusel    = alusel_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-encoded instructions with hand-computed expectations.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_ready, out_valid;
  logic [31:0] pc, inst, reg1_data_i, reg2_data_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o, rd;
  logic        reg1_read_enable, reg2_read_enable, rd_enable, illegal;
  logic [1:0]  fwd_valid, fwd_pending;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic [31:0] reg1, reg2, Imm, out_pc;
  logic [3:0]  aluop;
  logic [2:0]  alusel;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] InstOri   = 32'hFFF06093; // ori   x1,x0,-1
  localparam logic [31:0] InstAdd   = 32'h002081B3; // add   x3,x1,x2
  localparam logic [31:0] InstSub   = 32'h407302B3; // sub   x5,x6,x7
  localparam logic [31:0] InstAddi  = 32'h00408113; // addi  x2,x1,4
  localparam logic [31:0] InstLui   = 32'h12345237; // lui   x4,0x12345
  localparam logic [31:0] InstAuipc = 32'h00001297; // auipc x5,0x1
  localparam logic [31:0] InstAddi0 = 32'h00108013; // addi  x0,x1,1
  localparam logic [31:0] InstBad   = 32'h0000007F; // opcode 1111111
  localparam logic [31:0] InstBadOp = 32'h4020C1B3; // xor with funct7 0100000
  localparam logic [31:0] InstSrai  = 32'h40315093; // srai  x1,x2,3

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .NUM_FWD(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .pc               (pc),
    .inst             (inst),
    .reg1_addr_o      (reg1_addr_o),
    .reg2_addr_o      (reg2_addr_o),
    .reg1_read_enable (reg1_read_enable),
    .reg2_read_enable (reg2_read_enable),
    .reg1_data_i      (reg1_data_i),
    .reg2_data_i      (reg2_data_i),
    .fwd_valid        (fwd_valid),
    .fwd_pending      (fwd_pending),
    .fwd_addr         (fwd_addr),
    .fwd_data         (fwd_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .reg1             (reg1),
    .reg2             (reg2),
    .Imm              (Imm),
    .out_pc           (out_pc),
    .rd               (rd),
    .rd_enable        (rd_enable),
    .aluop            (aluop),
    .alusel           (alusel),
    .illegal          (illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc = 32'h0; inst = InstAdd; reg1_data_i = 32'h0; reg2_data_i = 32'h0;
    fwd_valid = 2'b00; fwd_pending = 2'b00; fwd_addr = '0; fwd_data = '0;
    #1 rst = 1'b1;
    #2;
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst aluop", 32'(aluop), 32'd15);
    check_eq("rst alusel", 32'(alusel), 32'd0);
    check_eq("rst reg1_addr", 32'(reg1_addr_o), 32'd0);
    check_eq("rst rd_en1", 32'(reg1_read_enable), 32'd0);
    check_eq("rst in_ready", 32'(in_ready), 32'd0);

    // Back-to-back issue
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; inst = InstOri; pc = 32'h40;
    #1;
    check_eq("ori in_ready", 32'(in_ready), 32'd1);
    check_eq("ori rd_en2", 32'(reg2_read_enable), 32'd0);
    @(negedge clk);
    check_eq("ori out_valid", 32'(out_valid), 32'd1);
    check_eq("ori reg2", reg2, 32'hFFFF_FFFF);
    check_eq("ori aluop", 32'(aluop), 32'd8);
    check_eq("ori alusel", 32'(alusel), 32'd1);
    check_eq("ori rd", 32'(rd), 32'd1);
    check_eq("ori rd_enable", 32'(rd_enable), 32'd1);
    inst = InstAdd; pc = 32'h44; reg1_data_i = 32'hAA; reg2_data_i = 32'd5;
    #1;
    check_eq("add reg2_addr", 32'(reg2_addr_o), 32'd2);
    @(negedge clk);
    check_eq("add out_valid", 32'(out_valid), 32'd1);
    check_eq("add reg1", reg1, 32'hAA);
    check_eq("add reg2", reg2, 32'd5);
    check_eq("add aluop", 32'(aluop), 32'd0);
    check_eq("add alusel", 32'(alusel), 32'd2);
    check_eq("add rd", 32'(rd), 32'd3);

    // Forwarding priority; pending ch1 is shadowed by non-pending ch0
    inst = InstSub; reg1_data_i = 32'hDEAD; reg2_data_i = 32'hBEEF;
    fwd_valid = 2'b11; fwd_pending = 2'b10;
    fwd_addr = {5'd6, 5'd6}; fwd_data = {32'h20, 32'h10};
    #1;
    check_eq("shadow in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_eq("fwd0 reg1", reg1, 32'h10);
    check_eq("fwd0 reg2", reg2, 32'hBEEF);
    check_eq("sub aluop", 32'(aluop), 32'd1);
    fwd_pending = 2'b00; fwd_addr = {5'd7, 5'd6}; fwd_data = {32'h30, 32'h10};
    @(negedge clk);
    check_eq("fwd1 reg1", reg1, 32'h10);
    check_eq("fwd1 reg2", reg2, 32'h30);

    // Load-use stall
    inst = InstAddi; fwd_valid = 2'b01; fwd_pending = 2'b01;
    fwd_addr = {5'd0, 5'd1}; fwd_data = {32'h0, 32'h0};
    #1;
    check_eq("stall in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_eq("stall bubble", 32'(out_valid), 32'd0);
    fwd_pending = 2'b00; fwd_data = {32'h0, 32'd7};
    #1;
    check_eq("unstall in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_eq("ld-use out_valid", 32'(out_valid), 32'd1);
    check_eq("ld-use reg1", reg1, 32'd7);
    check_eq("ld-use Imm", Imm, 32'd4);
    check_eq("ld-use reg2", reg2, 32'd4);
    fwd_valid = 2'b00;

    // LUI / AUIPC / x0 / illegal / shift
    inst = InstLui;
    @(negedge clk);
    check_eq("lui reg2", reg2, 32'h1234_5000);
    check_eq("lui reg1", reg1, 32'h0);
    check_eq("lui rd", 32'(rd), 32'd4);
    inst = InstAuipc; pc = 32'h100;
    @(negedge clk);
    check_eq("auipc reg1", reg1, 32'h100);
    check_eq("auipc reg2", reg2, 32'h1000);
    check_eq("auipc pc", out_pc, 32'h100);
    inst = InstAddi0;
    @(negedge clk);
    check_eq("x0 rd_enable", 32'(rd_enable), 32'd0);
    check_eq("x0 illegal", 32'(illegal), 32'd0);
    inst = InstBad;
    @(negedge clk);
    check_eq("bad out_valid", 32'(out_valid), 32'd1);
    check_eq("bad illegal", 32'(illegal), 32'd1);
    check_eq("bad aluop", 32'(aluop), 32'd15);
    check_eq("bad alusel", 32'(alusel), 32'd0);
    inst = InstBadOp;
    @(negedge clk);
    check_eq("badop illegal", 32'(illegal), 32'd1);
    check_eq("badop rd_enable", 32'(rd_enable), 32'd0);
    inst = InstSrai; reg1_data_i = 32'h55;
    @(negedge clk);
    check_eq("srai illegal", 32'(illegal), 32'd0);
    check_eq("srai reg1", reg1, 32'h55);
    check_eq("srai reg2", reg2, 32'd3);
    check_eq("srai aluop", 32'(aluop), 32'd7);
    check_eq("srai alusel", 32'(alusel), 32'd3);

    // Backpressure
    inst = InstOri; pc = 32'h200;
    @(negedge clk);
    check_eq("bp first pc", out_pc, 32'h200);
    out_ready = 1'b0; inst = InstAdd; pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check_eq("bp out_valid", 32'(out_valid), 32'd1);
      check_eq("bp out_pc", out_pc, 32'h200);
      check_eq("bp reg2", reg2, 32'hFFFF_FFFF);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp next pc", out_pc, 32'h204);
    check_eq("bp next aluop", 32'(aluop), 32'd0);

    // Flush
    flush = 1'b1; out_ready = 1'b0; inst = InstLui; pc = 32'h208;
    #1;
    check_eq("flush in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_eq("flush out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; out_ready = 1'b1; inst = InstOri; pc = 32'h300;
    @(negedge clk);
    check_eq("post-flush valid", 32'(out_valid), 32'd1);
    check_eq("post-flush pc", out_pc, 32'h300);

    // Asynchronous reset in the middle of a stall with a held output
    out_ready = 1'b0; inst = InstAddi;
    fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_addr = {5'd0, 5'd1};
    #1;
    check_eq("mid in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst out_valid", 32'(out_valid), 32'd0);
    check_eq("arst reg1", reg1, 32'h0);
    check_eq("arst reg2", reg2, 32'h0);
    check_eq("arst Imm", Imm, 32'h0);
    check_eq("arst out_pc", out_pc, 32'h0);
    check_eq("arst rd", 32'(rd), 32'd0);
    check_eq("arst aluop", 32'(aluop), 32'd15);
    check_eq("arst alusel", 32'(alusel), 32'd0);
    check_eq("arst reg1_addr", 32'(reg1_addr_o), 32'd0);
    check_eq("arst rd_en1", 32'(reg1_read_enable), 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; fwd_valid = 2'b00;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Registered, parametrised RV32I decode stage for the integer pipeline. It sits between the IF/ID latch and EX and drives register-file reads combinationally. It extends single-cycle ORI decode to the full OP-IMM, OP, LUI and AUIPC groups, and adds operand forwarding from NUM_FWD later stages, load-use stall detection, valid/ready flow control and flush. Results are held in an internal ID/EX output register.

## Interface
- XLEN, 32: datapath width; instruction width is always 32.
- NUM_FWD, 2: forwarding channels; index 0 is the youngest stage (EX) and has the highest priority.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard the held output and any instruction offered this cycle.
- in_valid  in  1  pc/inst valid.
- in_ready  out  1  stage accepts pc/inst this cycle.
- pc  in  XLEN  instruction address.
- inst  in  32  instruction word.
- reg1_addr_o, reg2_addr_o  out  5  register-file read addresses; combinational inst[19:15] / inst[24:20]; 0 while rst.
- reg1_read_enable, reg2_read_enable  out  1  combinational, per decoded format.
- reg1_data_i, reg2_data_i  in  XLEN  register-file read data, same cycle.
- fwd_valid  in  NUM_FWD  channel carries a result.
- fwd_pending  in  NUM_FWD  channel result not yet available (load in flight).
- fwd_addr  in  5*NUM_FWD  destination register per channel.
- fwd_data  in  XLEN*NUM_FWD  result per channel.
- out_valid  out  1  ID/EX register holds an instruction.
- out_ready  in  1  EX consumes the output this cycle.
- reg1, reg2, Imm, out_pc  out  XLEN  operands, immediate and pc; all registered.
- rd  out  5  destination register; registered.
- rd_enable  out  1  write-back enable; registered.
- aluop  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 NOP=15.
- alusel  out  3  NOP=0 LOGIC=1 ARITH=2 SHIFT=3 COMPARE=4.
- illegal  out  1  registered; unsupported opcode or funct encoding.

## Operation
- **OP-IMM (0010011).**
  - Imm is the sign-extended inst[31:20].
  - rs1 is read; reg2 carries Imm.
  - Shift immediates use shamt inst[24:20].
  - SRAI when inst[30]=1.
  - SLLI/SRLI/SRAI with inst[31:25] other than 0000000/0100000 set illegal.
- **OP (0110011).**
  - rs1 and rs2 are read.
  - funct7 0100000 is valid only with funct3 000 (SUB) or 101 (SRA).
  - Any funct7 other than 0000000/0100000 sets illegal.
- **LUI.** Imm = {inst[31:12], 12'b0}; reg1 = 0; reg2 = Imm; aluop ADD.
- **AUIPC.** Imm as LUI; reg1 = pc; reg2 = Imm; aluop ADD.
- **Operand select**, per source independently:
  - If read is disabled: 0, or Imm for reg2 when the format uses an immediate.
  - Else if the address is 0: 0.
  - Else the lowest-index channel with fwd_valid and a matching fwd_addr supplies fwd_data.
  - Otherwise reg*_data_i is used.
- **Stall.** Raised when the winning matching channel has fwd_pending=1 on an enabled, nonzero source. A pending channel shadowed by a younger non-pending match does not stall.
- **Illegal or unknown opcode.**
  - Payload: aluop NOP, alusel NOP, rd_enable 0, illegal 1.
  - The instruction still flows through the stage.
- **rd_enable.** Forced 0 when rd = 0.

## Timing
- in_ready = !rst && !flush && !stall && (!out_valid || out_ready); combinational.
- **Accept** (in_valid && in_ready): the output register loads on the next edge, with out_valid=1. Latency is 1 cycle.
- **Stall** with out_valid && out_ready: the output is consumed and out_valid drops to 0 (bubble). pc/inst must be held upstream.
- **Held output.** out_valid && !out_ready: all outputs remain stable and no accept occurs.
- **Flush** has priority over every other event: next cycle out_valid=0 and the input is not accepted. Payload registers may retain stale values.
- **Reset** (asynchronous, also mid-transfer):
  - out_valid=0; reg1, reg2, Imm, out_pc = 0; rd = 0; rd_enable = 0; aluop = NOP; alusel = NOP; illegal = 0.
  - Read addresses and enables are 0 while rst is high.
- Simultaneous consume and accept gives back-to-back transfers at full throughput.

## Test plan
- **Back-to-back issue.** With out_ready=1, issue ORI x1,x0,-1 then ADD x3,x1,x2 (reg2_data_i=5).
  - Cycle 1: reg2=0xFFFFFFFF, aluop OR, alusel LOGIC.
  - Cycle 2: ADD with reg2=5.
- **Forwarding priority.** Issue SUB x5,x6,x7 with ch0 {x6, 0x10} and ch1 {x6, 0x20, x7, 0x30} valid: reg1=0x10, reg2=0x30 from ch1, aluop SUB.
- **Load-use stall.** Issue ADDI x2,x1,4 with ch0 pending on x1.
  - in_ready=0 and the next output is a bubble.
  - Drop pending with data 7: the following cycle gives reg1=7, Imm=4.
- **LUI / AUIPC / x0 / illegal.**
  - LUI x4,0x12345 gives reg2=0x12345000.
  - AUIPC at pc 0x100 gives reg1=0x100.
  - ADDI x0,... gives rd_enable=0.
  - Opcode 1111111 gives illegal=1 and aluop NOP.
- **Backpressure.** Hold out_ready=0 for 3 cycles: outputs stay stable, in_ready=0, nothing is lost.
- **Flush and reset.**
  - Flush while out_valid=1 gives out_valid=0 next cycle.
  - Asserting rst mid-stall clears out_valid immediately, without waiting for a clock edge, and all outputs take their reset values.
